// File: rtl/acc_shifter_mx_cell_pkg.sv
// Shared constants and types for the 32-channel SRAM-fed serial shifter.
package acc_shifter_mx_cell_pkg;

    localparam int NCH    = 32;
    localparam int WORD_W = 32;

    typedef enum logic {
        SHT_KEEP = 1'b0,
        SHT_ZERO = 1'b1
    } sht_mode_e;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/acc_shifter_mx_cell_if.sv
// Control, SRAM read port and serial output bundle of the shifter cell.
interface acc_shifter_mx_cell_if
    import acc_shifter_mx_cell_pkg::*;
#(
    parameter int SRAM_ADDR_W = 10
);
    logic                         sram_en;
    logic [SRAM_ADDR_W-1:0]       sram_addr;
    logic [WORD_W-1:0]            sram_data;
    logic                         shift_start;
    logic                         shift_idle;
    logic [NCH-1:0]               shift_ctrl;
    logic [SRAM_ADDR_W*NCH-1:0]   start_addr;
    logic [SRAM_ADDR_W-1:0]       img_size;
    logic [NCH-1:0]               serial_output;
    logic [NCH-1:0]               serial_en;
    logic [NCH-1:0]               serial_start;

    modport master (
        output shift_start, shift_ctrl, start_addr, img_size, sram_data,
        input  shift_idle, sram_en, sram_addr, serial_output, serial_en, serial_start
    );

    modport slave (
        input  shift_start, shift_ctrl, start_addr, img_size, sram_data,
        output shift_idle, sram_en, sram_addr, serial_output, serial_en, serial_start
    );
endinterface

// File: rtl/acc_shifter_mx_cell_lane.sv
// One channel: staging register, zero mask, 32-bit shift register and
// registered serial outputs.
module acc_shifter_lane
    import acc_shifter_mx_cell_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_ld,
    input  sht_mode_e         cfg_mode,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              load,
    input  logic              shift,
    output logic              ser_out,
    output logic              ser_en,
    output logic              ser_start
);
    logic [WORD_W-1:0] stage_q, stage_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [WORD_W-1:0] word;
    sht_mode_e         mode_q, mode_d;
    logic              out_q, out_d;
    logic              en_q, en_d;
    logic              start_q, start_d;

    always_comb begin
        stage_d = wr_en ? wr_data : stage_q;
        mode_d  = cfg_ld ? cfg_mode : mode_q;
        // Load takes the staging value including a write landing this cycle.
        word    = (mode_q == SHT_ZERO) ? '0 : stage_d;
        shreg_d = shreg_q;
        out_d   = 1'b0;
        en_d    = 1'b0;
        start_d = 1'b0;
        if (load) begin
            out_d   = word[0];
            en_d    = 1'b1;
            start_d = 1'b1;
            shreg_d = word >> 1;
        end else if (shift) begin
            out_d   = shreg_q[0];
            en_d    = 1'b1;
            shreg_d = shreg_q >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stage_q <= '0;
            shreg_q <= '0;
            mode_q  <= SHT_KEEP;
            out_q   <= 1'b0;
            en_q    <= 1'b0;
            start_q <= 1'b0;
        end else begin
            stage_q <= stage_d;
            shreg_q <= shreg_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
            en_q    <= en_d;
            start_q <= start_d;
        end
    end

    assign ser_out   = out_q;
    assign ser_en    = en_q;
    assign ser_start = start_q;
endmodule

// File: rtl/acc_shifter_mx_cell.sv
// Fetches one SRAM word per channel per word slot and streams them LSB first.
// States: IDLE wait start | FILL fetch word 0 | RUN shift k, fetch k+1 | DRAIN shift last word
module acc_shifter_mx_cell
    import acc_shifter_mx_cell_pkg::*;
#(
    parameter int SRAM_DEPTH = 1024
)(
    input logic                  clk,
    input logic                  reset_n,
    acc_shifter_mx_cell_if.slave bus
);
    localparam int SRAM_ADDR_W = clog2(SRAM_DEPTH);
    localparam int CH_W        = clog2(NCH);

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RUN, ST_DRAIN} state_e;

    state_e                 state_q, state_d;
    logic [SRAM_ADDR_W-1:0] base_q [NCH];
    logic [SRAM_ADDR_W-1:0] base_d [NCH];
    logic [SRAM_ADDR_W-1:0] size_q, size_d;
    logic                   sram_en_q, sram_en_d;
    logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [CH_W-1:0]        rd_ch_q, rd_ch_d;
    logic [SRAM_ADDR_W-1:0] rd_word_q, rd_word_d;
    logic                   dv_q, dv_d;
    logic [CH_W-1:0]        dv_ch_q, dv_ch_d;
    logic                   dv_last_q, dv_last_d;
    logic [CH_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic                   shifting_q, shifting_d;
    logic                   idle_q, idle_d;

    logic                   accept, load, shift, last_rd;
    logic [CH_W-1:0]        nxt_ch;
    logic [SRAM_ADDR_W-1:0] nxt_word;
    logic [NCH-1:0]         ser_out, ser_en, ser_start;

    always_comb begin
        accept   = (state_q == ST_IDLE) && bus.shift_start;
        load     = dv_q && (dv_ch_q == CH_W'(NCH-1));
        shift    = shifting_q && (bit_cnt_q != '0);
        last_rd  = (rd_ch_q == CH_W'(NCH-1)) && (rd_word_q == size_q);
        nxt_ch   = rd_ch_q + CH_W'(1);
        nxt_word = (rd_ch_q == CH_W'(NCH-1)) ? rd_word_q + SRAM_ADDR_W'(1) : rd_word_q;

        state_d     = state_q;
        idle_d      = idle_q;
        size_d      = size_q;
        base_d      = base_q;
        sram_en_d   = 1'b0;
        sram_addr_d = sram_addr_q;
        rd_ch_d     = rd_ch_q;
        rd_word_d   = rd_word_q;
        dv_d        = sram_en_q;
        dv_ch_d     = rd_ch_q;
        dv_last_d   = (rd_word_q == size_q);
        bit_cnt_d   = bit_cnt_q;
        shifting_d  = shifting_q;

        if (load) begin
            bit_cnt_d  = CH_W'(1);
            shifting_d = 1'b1;
        end else if (shift) begin
            bit_cnt_d  = bit_cnt_q + CH_W'(1);
        end else if (shifting_q) begin
            shifting_d = 1'b0;
        end

        // Reads run back to back across word boundaries until the last word.
        if (sram_en_q && !last_rd) begin
            sram_en_d   = 1'b1;
            rd_ch_d     = nxt_ch;
            rd_word_d   = nxt_word;
            sram_addr_d = base_q[nxt_ch] + nxt_word;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_FILL;
                    idle_d      = 1'b0;
                    size_d      = bus.img_size;
                    for (int c = 0; c < NCH; c++)
                        base_d[c] = bus.start_addr[c*SRAM_ADDR_W +: SRAM_ADDR_W];
                    sram_en_d   = 1'b1;
                    rd_ch_d     = '0;
                    rd_word_d   = '0;
                    sram_addr_d = bus.start_addr[0 +: SRAM_ADDR_W];
                end
            end
            ST_FILL: begin
                if (load)
                    state_d = dv_last_q ? ST_DRAIN : ST_RUN;
            end
            ST_RUN: begin
                if (load && dv_last_q)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (shifting_q && (bit_cnt_q == '0)) begin
                    state_d = ST_IDLE;
                    idle_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            idle_q      <= 1'b1;
            size_q      <= '0;
            for (int c = 0; c < NCH; c++)
                base_q[c] <= '0;
            sram_en_q   <= 1'b0;
            sram_addr_q <= '0;
            rd_ch_q     <= '0;
            rd_word_q   <= '0;
            dv_q        <= 1'b0;
            dv_ch_q     <= '0;
            dv_last_q   <= 1'b0;
            bit_cnt_q   <= '0;
            shifting_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idle_q      <= idle_d;
            size_q      <= size_d;
            base_q      <= base_d;
            sram_en_q   <= sram_en_d;
            sram_addr_q <= sram_addr_d;
            rd_ch_q     <= rd_ch_d;
            rd_word_q   <= rd_word_d;
            dv_q        <= dv_d;
            dv_ch_q     <= dv_ch_d;
            dv_last_q   <= dv_last_d;
            bit_cnt_q   <= bit_cnt_d;
            shifting_q  <= shifting_d;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        acc_shifter_lane u_lane (
            .clk       (clk),
            .reset_n   (reset_n),
            .cfg_ld    (accept),
            .cfg_mode  (sht_mode_e'(bus.shift_ctrl[c])),
            .wr_en     (dv_q && (dv_ch_q == CH_W'(c))),
            .wr_data   (bus.sram_data),
            .load      (load),
            .shift     (shift),
            .ser_out   (ser_out[c]),
            .ser_en    (ser_en[c]),
            .ser_start (ser_start[c])
        );
    end

    assign bus.shift_idle    = idle_q;
    assign bus.sram_en       = sram_en_q;
    assign bus.sram_addr     = sram_addr_q;
    assign bus.serial_output = ser_out;
    assign bus.serial_en     = ser_en;
    assign bus.serial_start  = ser_start;
endmodule

// File: tb/tb_acc_shifter_mx_cell.sv
// Directed and randomized transfers checked against a word-level model of the
// SRAM contents and per-channel KEEP/ZERO modes.
module tb_acc_shifter_mx_cell;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int NCH   = 32;

    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] mem [DEPTH];
    logic [31:0] cfg_ctrl;
    int          cfg_base [NCH];
    int          cfg_size;

    logic [31:0] got_w [NCH][64];
    int          got_n [NCH];
    int          bidx [NCH];
    int          en_cnt [NCH];
    logic [31:0] cur [NCH];

    acc_shifter_mx_cell_if #(.SRAM_ADDR_W(AW)) bus ();

    acc_shifter_mx_cell #(.SRAM_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.sram_en) bus.sram_data <= mem[bus.sram_addr];

    task automatic chk(input string name, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, observed, expected);
        end
    endtask

    function automatic logic [31:0] exp_word(input int c, input int k);
        if (cfg_ctrl[c]) return 32'h0;
        return mem[(cfg_base[c] + k) % DEPTH];
    endfunction

    task automatic do_xfer(input string tag, input int busy_pulse_at, input int abort_at);
        int busy_exp, idle_n, first_en_n, last_en_n, rd_cnt;
        int zero_bad, align_bad, start_bad, post_en, lim, bad_k;
        logic [NCH-1:0] en_v, out_v, st_v;
        busy_exp = (cfg_size + 2) * 32 + 2;
        idle_n = 0; first_en_n = 0; last_en_n = 0; rd_cnt = 0;
        zero_bad = 0; align_bad = 0; start_bad = 0; post_en = 0;
        for (int c = 0; c < NCH; c++) begin
            got_n[c] = 0; bidx[c] = 0; en_cnt[c] = 0; cur[c] = '0;
        end
        @(negedge clk);
        bus.shift_ctrl = cfg_ctrl;
        bus.img_size   = cfg_size[AW-1:0];
        for (int c = 0; c < NCH; c++) bus.start_addr[c*AW +: AW] = cfg_base[c][AW-1:0];
        bus.shift_start = 1'b1;
        for (int n = 1; n <= busy_exp + 8; n++) begin
            @(negedge clk);
            bus.shift_start = 1'b0;
            if (n == busy_pulse_at) begin
                bus.shift_start = 1'b1;
                bus.img_size    = '0;
                bus.shift_ctrl  = ~cfg_ctrl;
            end
            if (n == 1) chk({tag, "/idle_fall"}, 64'(bus.shift_idle), 64'd0);
            if (abort_at != 0 && n == abort_at) begin
                reset_n = 1'b0;
                @(negedge clk);
                chk({tag, "/rst_en"},    64'(bus.serial_en),     64'd0);
                chk({tag, "/rst_out"},   64'(bus.serial_output), 64'd0);
                chk({tag, "/rst_start"}, 64'(bus.serial_start),  64'd0);
                chk({tag, "/rst_idle"},  64'(bus.shift_idle),    64'd1);
                chk({tag, "/rst_sram"},  64'(bus.sram_en),       64'd0);
                chk({tag, "/rst_addr"},  64'(bus.sram_addr),     64'd0);
                reset_n = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    if (bus.serial_en != '0 || bus.sram_en) post_en++;
                end
                chk({tag, "/rst_quiet"}, 64'(post_en), 64'd0);
                return;
            end
            en_v  = bus.serial_en;
            out_v = bus.serial_output;
            st_v  = bus.serial_start;
            if (bus.sram_en) rd_cnt++;
            if (bus.shift_idle && idle_n == 0 && n > 1) idle_n = n;
            for (int c = 0; c < NCH; c++) begin
                if (st_v[c] !== (en_v[c] && bidx[c] == 0)) start_bad++;
                if (en_v[c]) begin
                    cur[c][bidx[c]] = out_v[c];
                    en_cnt[c]++;
                    if (bidx[c] == 31) begin
                        if (got_n[c] < 64) got_w[c][got_n[c]] = cur[c];
                        got_n[c]++;
                        bidx[c] = 0;
                    end else begin
                        bidx[c]++;
                    end
                end else if (out_v[c]) begin
                    zero_bad++;
                end
            end
            if (en_v != '0 && en_v != '1) align_bad++;
            if (en_v[0]) begin
                if (first_en_n == 0) first_en_n = n;
                last_en_n = n;
            end
        end
        chk({tag, "/first_bit"}, 64'(first_en_n), 64'd34);
        chk({tag, "/idle_rise"}, 64'(idle_n), 64'(busy_exp));
        chk({tag, "/reads"},     64'(rd_cnt), 64'(32 * (cfg_size + 1)));
        chk({tag, "/contig"},    64'(last_en_n - first_en_n + 1), 64'(32 * (cfg_size + 1)));
        chk({tag, "/out_no_en"}, 64'(zero_bad), 64'd0);
        chk({tag, "/en_align"},  64'(align_bad), 64'd0);
        chk({tag, "/start_pos"}, 64'(start_bad), 64'd0);
        chk({tag, "/idle_end"},  64'(bus.shift_idle), 64'd1);
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("%s/ch%0d_words", tag, c), 64'(got_n[c]), 64'(cfg_size + 1));
            chk($sformatf("%s/ch%0d_pulses", tag, c), 64'(en_cnt[c]), 64'(32 * (cfg_size + 1)));
            lim = got_n[c];
            if (lim > cfg_size + 1) lim = cfg_size + 1;
            if (lim > 64) lim = 64;
            bad_k = lim - 1;
            for (int k = lim - 1; k >= 0; k--)
                if (got_w[c][k] !== exp_word(c, k)) bad_k = k;
            if (bad_k >= 0)
                chk($sformatf("%s/ch%0d_word%0d", tag, c, bad_k), 64'(got_w[c][bad_k]), 64'(exp_word(c, bad_k)));
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = (i < 64) ? 32'(i) : $urandom;
        reset_n         = 1'b0;
        bus.shift_start = 1'b0;
        bus.shift_ctrl  = '0;
        bus.start_addr  = '0;
        bus.img_size    = '0;
        repeat (3) @(negedge clk);
        chk("reset/idle",  64'(bus.shift_idle),    64'd1);
        chk("reset/sram",  64'(bus.sram_en),       64'd0);
        chk("reset/addr",  64'(bus.sram_addr),     64'd0);
        chk("reset/en",    64'(bus.serial_en),     64'd0);
        chk("reset/out",   64'(bus.serial_output), 64'd0);
        chk("reset/start", 64'(bus.serial_start),  64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // all KEEP, ramp words 0..31, with an ignored start pulse mid-transfer
        cfg_ctrl = '0; cfg_size = 31;
        for (int c = 0; c < NCH; c++) cfg_base[c] = 0;
        do_xfer("keep_all", 200, 0);

        cfg_ctrl = '1;
        do_xfer("zero_all", 0, 0);

        cfg_ctrl = $urandom;
        do_xfer("mix", 500, 0);

        cfg_ctrl = '0; cfg_size = 3;
        for (int c = 0; c < NCH; c++) cfg_base[c] = c;
        do_xfer("stagger", 0, 0);

        cfg_size = 1;
        for (int c = 0; c < NCH; c++) cfg_base[c] = DEPTH - 1;
        do_xfer("wrap", 0, 0);

        for (int r = 0; r < 3; r++) begin
            cfg_ctrl = $urandom;
            cfg_size = $urandom_range(0, 4);
            for (int c = 0; c < NCH; c++) cfg_base[c] = $urandom_range(0, DEPTH - 1);
            do_xfer($sformatf("rand%0d", r), 0, 0);
        end

        cfg_ctrl = '0; cfg_size = 31;
        for (int c = 0; c < NCH; c++) cfg_base[c] = 0;
        do_xfer("abort", 0, 150);

        cfg_ctrl = $urandom; cfg_size = 0;
        for (int c = 0; c < NCH; c++) cfg_base[c] = $urandom_range(0, DEPTH - 1);
        do_xfer("after_rst", 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/acc_shifter_mx_cell.md
ACC_SHIFTER_MX_CELL -- requirements
Module: acc_shifter_mx_cell

Interface
REQ-001 SHALL have parameter SRAM_DEPTH, default 1024, words in the attached single-port SRAM.
REQ-002 SHALL derive localparam SRAM_ADDR_W = ceil(log2(SRAM_DEPTH)), default 10; NCH = 32, the channel count, fixed.
REQ-003 SHALL have one clock and a synchronous, active-low reset; ports named clk and reset_n as in the codebase.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset_n  in  1  synchronous active-low reset.
REQ-006 sram_en  out  1  SRAM read enable.
REQ-007 sram_addr  out  SRAM_ADDR_W  SRAM read address.
REQ-008 sram_data  in  32  SRAM read data, valid the cycle after sram_en (1-cycle latency).
REQ-009 shift_start  in  1  one-cycle start pulse.
REQ-010 shift_idle  out  1  high when no transfer is active.
REQ-011 shift_ctrl  in  32  per-channel mode: bit c = 0 SHT_KEEP, 1 SHT_ZERO.
REQ-012 start_addr  in  SRAM_ADDR_W*32  per-channel base address; channel c occupies slice [c*SRAM_ADDR_W +: SRAM_ADDR_W].
REQ-013 img_size  in  SRAM_ADDR_W  word count minus one.
REQ-014 serial_output  out  32  per-channel serial data bit.
REQ-015 serial_en  out  32  per-channel bit-valid.
REQ-016 serial_start  out  32  per-channel first-bit-of-word marker.

Function
REQ-017 SHALL sample shift_ctrl, start_addr and img_size on the shift_start cycle when idle; shift_start while busy SHALL be ignored.
REQ-018 For word index k = 0..img_size, every channel SHALL emit one 32-bit word, LSB first, one bit per serial_en cycle.
REQ-019 SHT_KEEP channel word k SHALL equal SRAM[(start_addr[c]+k) mod 2^SRAM_ADDR_W].
REQ-020 SHT_ZERO channel word k SHALL be 0 and still carry 32 serial_en pulses per word.
REQ-021 Fetch SHALL be time-multiplexed: for each k, issue 32 consecutive reads, channel 0..31 in order, into a per-channel staging register.
REQ-022 State machine IDLE -> FILL (fetch word 0) -> RUN (shift word k while prefetching k+1) -> DRAIN (shift last word, no fetch) -> IDLE.
REQ-023 After the last staging write of a word, staging SHALL load into the shift registers; serial_en SHALL then be high on all 32 channels for exactly 32 consecutive cycles.
REQ-024 Consecutive words SHALL be emitted back-to-back without gaps.
REQ-025 serial_start[c] SHALL be high with bit 0 of each word only.
REQ-026 serial_output, serial_en and serial_start SHALL be registered and mutually aligned; serial_output SHALL be 0 when serial_en is 0.
REQ-027 First serial bit SHALL appear 34 cycles after the shift_start cycle (1 cycle latch, 32 reads, 1 cycle SRAM latency); total busy time (img_size+2)*32+2 cycles.
REQ-028 sram_en SHALL be high only for issued reads; sram_addr SHALL hold its last value otherwise.
REQ-029 shift_idle SHALL fall the cycle after an accepted shift_start and rise the cycle after the last serial bit.
REQ-030 img_size = 0 SHALL emit exactly one word per channel.

Reset
REQ-031 With reset_n low at a clock edge: state IDLE, shift_idle=1, sram_en=0, sram_addr=0, serial_output=0, serial_en=0, serial_start=0, all shift and staging registers 0.
REQ-032 Reset mid-transfer SHALL abort immediately; no further bits are emitted, and a subsequent shift_start starts a fresh transfer.

Structure
REQ-033 Shared package SHALL hold NCH=32, WORD_W=32, the clog2 function and the ctrl enum {SHT_KEEP=0, SHT_ZERO=1}.
REQ-034 A per-channel sub-module acc_shifter_lane (staging reg, 32-bit shift reg, zero mask, serial outputs) SHALL be instantiated 32 times.
REQ-035 The top level SHALL hold the FSM, word and channel counters and the address generator.

Verification
REQ-036 SRAM[i]=i for i=0..31, img_size=31, all start_addr=0, all KEEP -> every channel emits 0x0..0x1F in order, then shift_idle=1.
REQ-037 Same setup, all ZERO -> every channel emits 32 words of 0x00000000 with 1024 serial_en pulses.
REQ-038 Random per-channel KEEP/ZERO mix -> KEEP channels emit 0..31, ZERO channels emit zeros, no extra words on any channel.
REQ-039 start_addr[c]=c, img_size=3, SRAM[i]=i, KEEP -> channel c emits c, c+1, c+2, c+3; start_addr=SRAM_DEPTH-1, img_size=1 -> words SRAM[1023], SRAM[0].
REQ-040 Assert reset_n low mid-RUN -> all outputs 0 and shift_idle=1 the next cycle; then shift_start with img_size=0 -> exactly one word per channel, first bit 34 cycles after the start cycle.
